// File: rtl/data_memory_hs.sv
`default_nettype none
// ============================================================================
// Module   : data_memory_hs
// Purpose  : RV32I data memory behind a valid/ready request channel with a
//            registered one-cycle response pulse and WAIT_CYCLES wait states.
//            Handles LB/LH/LW/LBU/LHU and SB/SH/SW with little-endian lanes,
//            flags illegal, out-of-range and misaligned accesses, and clears
//            the word array one word per cycle after every reset.
// Ports    : clk        - clock, rising edge
//            reset_n    - asynchronous active-low reset
//            req_valid  - request present
//            req_ready  - request accepted when req_valid & req_ready
//            req_we     - 1 = store, 0 = load
//            addr       - byte address
//            fun3       - RISC-V funct3 (size / signedness)
//            wdata      - store data (low byte/half/word used)
//            rsp_valid  - one-cycle response pulse
//            rdata      - load result (0 for stores and errors)
//            rsp_err    - error flag, qualified by rsp_valid
//            init_done  - post-reset clear has completed
// Options  : `define MISALIGN_SPLIT_EN to split misaligned halfword/word
//            accesses that cross a word boundary over two words (one extra
//            cycle). Undefined: every misaligned access is an error.
// Revision : 1.0 - initial release
// ============================================================================
module data_memory_hs #(
    parameter int SIZE        = 1024,
    parameter int WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] addr,
    input  logic [2:0]  fun3,
    input  logic [31:0] wdata,
    output logic        rsp_valid,
    output logic [31:0] rdata,
    output logic        rsp_err,
    output logic        init_done
);

    localparam int              C_WORDS    = SIZE / 4;
    localparam int              C_AW       = $clog2(C_WORDS);
    localparam logic [C_AW-1:0] C_LAST_IDX = C_AW'(C_WORDS - 1);
    localparam logic [2:0]      C_WAIT     = 3'(WAIT_CYCLES);

    typedef enum logic [1:0] {
        S_INIT = 2'd0,
        S_IDLE = 2'd1,
        S_BUSY = 2'd2,
        S_RESP = 2'd3
    } state_t;

    state_t            r_state;
    state_t            w_next_state;

    logic [31:0]       mem [C_WORDS];

    logic [C_AW-1:0]   r_idx;
    logic [2:0]        r_cnt;
    logic              r_second;
    logic              r_we;
    logic [31:0]       r_addr;
    logic [2:0]        r_fun3;
    logic [31:0]       r_wdata;
    logic              r_rsp_valid;
    logic [31:0]       r_rdata;
    logic              r_rsp_err;
    logic              r_init_done;

    // ------------------------------------------------------------------
    // Decode of the latched request
    // ------------------------------------------------------------------
    logic [1:0]        w_size_m1;
    logic [31:0]       w_mask;
    logic              w_is_h;
    logic              w_is_w;
    logic              w_illegal;
    logic [32:0]       w_last;
    logic              w_oor;
    logic              w_err;
    logic              w_split;

    always_comb begin
        w_size_m1 = 2'd0;
        w_mask    = 32'h0000_0000;
        case (r_fun3[1:0])
            2'b00:   begin w_size_m1 = 2'd0; w_mask = 32'h0000_00FF; end
            2'b01:   begin w_size_m1 = 2'd1; w_mask = 32'h0000_FFFF; end
            2'b10:   begin w_size_m1 = 2'd3; w_mask = 32'hFFFF_FFFF; end
            default: begin w_size_m1 = 2'd0; w_mask = 32'h0000_0000; end
        endcase
    end

    assign w_is_h    = (r_fun3[1:0] == 2'b01);
    assign w_is_w    = (r_fun3[1:0] == 2'b10);
    assign w_illegal = (r_fun3 == 3'b011) | (r_fun3[2:1] == 2'b11) | (r_we & r_fun3[2]);

    // Range is judged on the last byte touched; 33 bits keeps addresses near
    // 2^32 from wrapping back into range.
    assign w_last = {1'b0, r_addr} + {31'd0, w_size_m1};
    assign w_oor  = (w_last >= 33'(SIZE));

`ifdef MISALIGN_SPLIT_EN
    logic w_cross;
    assign w_cross = (w_is_h & (r_addr[1:0] == 2'b11)) | (w_is_w & (r_addr[1:0] != 2'b00));
    assign w_err   = w_illegal | w_oor;
    assign w_split = w_cross & ~w_err;
`else
    logic w_misalign;
    assign w_misalign = (w_is_h & r_addr[0]) | (w_is_w & (r_addr[1:0] != 2'b00));
    assign w_err      = w_illegal | w_oor | w_misalign;
    assign w_split    = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Datapath: the addressed word and its successor form a 64-bit window
    // so that aligned and word-crossing accesses share one shift/merge.
    // ------------------------------------------------------------------
    logic [C_AW-1:0]   w_wa;
    logic [C_AW-1:0]   w_wb;
    logic [4:0]        w_sh;
    logic [63:0]       w_pair;
    logic [31:0]       w_lane;
    logic [63:0]       w_mask64;
    logic [63:0]       w_merged;
    logic [31:0]       w_load;

    assign w_wa     = r_addr[C_AW+1:2];
    assign w_wb     = w_wa + 1'b1;
    assign w_sh     = {r_addr[1:0], 3'b000};
    assign w_pair   = {mem[w_wb], mem[w_wa]};
    assign w_lane   = 32'(w_pair >> w_sh);
    assign w_mask64 = {32'd0, w_mask} << w_sh;
    assign w_merged = (w_pair & ~w_mask64) | ({32'd0, r_wdata & w_mask} << w_sh);

    always_comb begin
        w_load = 32'h0000_0000;
        case (r_fun3)
            3'b000:  w_load = {{24{w_lane[7]}},  w_lane[7:0]};
            3'b001:  w_load = {{16{w_lane[15]}}, w_lane[15:0]};
            3'b010:  w_load = w_lane;
            3'b100:  w_load = {24'd0, w_lane[7:0]};
            3'b101:  w_load = {16'd0, w_lane[15:0]};
            default: w_load = 32'h0000_0000;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_INIT;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state and array write control
    // ------------------------------------------------------------------
    logic              w_mem_we;
    logic [C_AW-1:0]   w_mem_idx;
    logic [31:0]       w_mem_data;
    logic              w_first;
    logic              w_done;

    always_comb begin
        w_next_state = r_state;
        w_mem_we     = 1'b0;
        w_mem_idx    = r_idx;
        w_mem_data   = 32'h0000_0000;
        w_first      = 1'b0;
        w_done       = 1'b0;
        case (r_state)
            S_INIT: begin
                w_mem_we = 1'b1;
                if (r_idx == C_LAST_IDX) begin
                    w_next_state = S_IDLE;
                end
            end
            S_IDLE: begin
                if (req_valid) begin
                    w_next_state = S_BUSY;
                end
            end
            S_BUSY: begin
                if (r_cnt == 3'd0) begin
                    if (w_split && !r_second) begin
                        // First half of a split access: lower word only.
                        w_first = 1'b1;
                    end else begin
                        w_done       = 1'b1;
                        w_next_state = S_RESP;
                    end
                    if (r_we && !w_err) begin
                        w_mem_we = 1'b1;
                        if (w_split && r_second) begin
                            w_mem_idx  = w_wb;
                            w_mem_data = w_merged[63:32];
                        end else begin
                            w_mem_idx  = w_wa;
                            w_mem_data = w_merged[31:0];
                        end
                    end
                end
            end
            S_RESP: begin
                w_next_state = S_IDLE;
            end
            default: begin
                w_next_state = S_INIT;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Control / response registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_idx       <= '0;
            r_cnt       <= 3'd0;
            r_second    <= 1'b0;
            r_we        <= 1'b0;
            r_addr      <= 32'h0000_0000;
            r_fun3      <= 3'b000;
            r_wdata     <= 32'h0000_0000;
            r_rsp_valid <= 1'b0;
            r_rdata     <= 32'h0000_0000;
            r_rsp_err   <= 1'b0;
            r_init_done <= 1'b0;
        end else begin
            case (r_state)
                S_INIT: begin
                    r_idx <= r_idx + 1'b1;
                    if (r_idx == C_LAST_IDX) begin
                        r_init_done <= 1'b1;
                    end
                end
                S_IDLE: begin
                    if (req_valid) begin
                        r_we     <= req_we;
                        r_addr   <= addr;
                        r_fun3   <= fun3;
                        r_wdata  <= wdata;
                        r_cnt    <= C_WAIT;
                        r_second <= 1'b0;
                    end
                end
                S_BUSY: begin
                    if (r_cnt != 3'd0) begin
                        r_cnt <= r_cnt - 3'd1;
                    end
                    if (w_first) begin
                        r_second <= 1'b1;
                    end
                    if (w_done) begin
                        r_rsp_valid <= 1'b1;
                        r_rsp_err   <= w_err;
                        r_rdata     <= (r_we || w_err) ? 32'h0000_0000 : w_load;
                    end
                end
                S_RESP: begin
                    r_rsp_valid <= 1'b0;
                end
                default: begin
                    r_rsp_valid <= 1'b0;
                end
            endcase
        end
    end

    // Array has no reset: its contents are cleared by the INIT sweep.
    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            mem[w_mem_idx] <= w_mem_data;
        end
    end

    assign req_ready = (r_state == S_IDLE);
    assign rsp_valid = r_rsp_valid;
    assign rdata     = r_rdata;
    assign rsp_err   = r_rsp_err;
    assign init_done = r_init_done;

endmodule
`default_nettype wire

// File: tb/tb_data_memory_hs.sv
`default_nettype none
// ============================================================================
// Module   : tb_data_memory_hs
// Purpose  : Self-checking bench for data_memory_hs. Three instances with
//            different SIZE / WAIT_CYCLES; a byte-array reference model gives
//            expected load data, error flag and latency.
// Revision : 1.0 - initial release
// ============================================================================
module tb_data_memory_hs;

    localparam int N = 3;

    function automatic int sz_of(input int i);
        case (i)
            0:       return 1024;
            1:       return 64;
            default: return 32;
        endcase
    endfunction

    function automatic int wait_of(input int i);
        case (i)
            0:       return 1;
            1:       return 0;
            default: return 3;
        endcase
    endfunction

    logic        clk;
    logic        reset_n;
    logic        req_valid [N];
    logic        req_ready [N];
    logic        req_we    [N];
    logic [31:0] addr      [N];
    logic [2:0]  fun3      [N];
    logic [31:0] wdata     [N];
    logic        rsp_valid [N];
    logic [31:0] rdata     [N];
    logic        rsp_err   [N];
    logic        init_done [N];

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] mdl [N][1024];

    data_memory_hs #(.SIZE(1024), .WAIT_CYCLES(1)) u_dut0 (
        .clk(clk), .reset_n(reset_n), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
        .req_we(req_we[0]), .addr(addr[0]), .fun3(fun3[0]), .wdata(wdata[0]),
        .rsp_valid(rsp_valid[0]), .rdata(rdata[0]), .rsp_err(rsp_err[0]), .init_done(init_done[0]));

    data_memory_hs #(.SIZE(64), .WAIT_CYCLES(0)) u_dut1 (
        .clk(clk), .reset_n(reset_n), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
        .req_we(req_we[1]), .addr(addr[1]), .fun3(fun3[1]), .wdata(wdata[1]),
        .rsp_valid(rsp_valid[1]), .rdata(rdata[1]), .rsp_err(rsp_err[1]), .init_done(init_done[1]));

    data_memory_hs #(.SIZE(32), .WAIT_CYCLES(3)) u_dut2 (
        .clk(clk), .reset_n(reset_n), .req_valid(req_valid[2]), .req_ready(req_ready[2]),
        .req_we(req_we[2]), .addr(addr[2]), .fun3(fun3[2]), .wdata(wdata[2]),
        .rsp_valid(rsp_valid[2]), .rdata(rdata[2]), .rsp_err(rsp_err[2]), .init_done(init_done[2]));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%h required=%h", name, act, exp);
        end
    endtask

    // Reference model: memory as bytes, rules applied directly.
    task automatic model_access(input int i, input logic we, input logic [31:0] a,
                                input logic [2:0] f3, input logic [31:0] wd,
                                output logic [31:0] rd, output logic er, output int extra);
        int n;
        logic illegal;
        logic oor;
        logic [31:0] v;
        case (f3[1:0])
            2'd0:    n = 1;
            2'd1:    n = 2;
            2'd2:    n = 4;
            default: n = 1;
        endcase
        illegal = (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7) || (we && (f3 == 3'd4 || f3 == 3'd5));
        oor     = (longint'(a) + longint'(n) - 1) >= longint'(sz_of(i));
`ifdef MISALIGN_SPLIT_EN
        er    = illegal || oor;
        extra = (!er && ((a % 4) + n > 4)) ? 1 : 0;
`else
        er    = illegal || oor || ((a % n) != 0);
        extra = 0;
`endif
        rd = 32'h0;
        if (!er) begin
            if (we) begin
                for (int b = 0; b < n; b++) mdl[i][int'(a) + b] = wd[8*b +: 8];
            end else begin
                v = 32'h0;
                for (int b = 0; b < n; b++) v[8*b +: 8] = mdl[i][int'(a) + b];
                if (!f3[2] && n == 1 && v[7])  v = v | 32'hFFFF_FF00;
                if (!f3[2] && n == 2 && v[15]) v = v | 32'hFFFF_0000;
                rd = v;
            end
        end
    endtask

    // One request/response; lat = edges from accept to the rsp_valid cycle.
    task automatic do_req(input int i, input logic we, input logic [31:0] a, input logic [2:0] f3,
                          input logic [31:0] wd, output logic [31:0] rd, output logic er, output int lat);
        int k;
        @(negedge clk);
        req_valid[i] = 1'b1; req_we[i] = we; addr[i] = a; fun3[i] = f3; wdata[i] = wd;
        k = 0;
        while (req_ready[i] !== 1'b1 && k < 100) begin
            @(negedge clk);
            k++;
        end
        rd = 32'h0; er = 1'b0; lat = -1;
        if (k >= 100) begin
            n_checks++; n_fail++;
            $display("FAIL accept_timeout inst=%0d: actual=ready_low required=accept", i);
            req_valid[i] = 1'b0;
            return;
        end
        @(posedge clk);
        @(negedge clk);
        // Scramble inputs so that only accept-edge sampling gives correct results.
        req_valid[i] = 1'b0;
        req_we[i]    = 1'($urandom_range(0, 1));
        addr[i]      = $urandom;
        fun3[i]      = 3'($urandom_range(0, 7));
        wdata[i]     = $urandom;
        for (int e = 1; e <= 20; e++) begin
            @(posedge clk);
            #1;
            if (rsp_valid[i] === 1'b1) begin
                lat = e;
                break;
            end
        end
        rd = rdata[i];
        er = rsp_err[i];
        if (lat > 0) begin
            @(posedge clk);
            #1;
            chk("rsp_width", 32'(rsp_valid[i]), 32'd0);
        end
    endtask

    task automatic run_op(input int i, input logic we, input logic [31:0] a, input logic [2:0] f3,
                          input logic [31:0] wd, input logic use_tbl,
                          input logic [31:0] t_rd, input logic t_er);
        logic [31:0] m_rd, d_rd;
        logic        m_er, d_er;
        int          extra, lat;
        model_access(i, we, a, f3, wd, m_rd, m_er, extra);
        do_req(i, we, a, f3, wd, d_rd, d_er, lat);
        chk("rdata",   d_rd, use_tbl ? t_rd : m_rd);
        chk("rsp_err", 32'(d_er), 32'(use_tbl ? t_er : m_er));
        chk("latency", lat, wait_of(i) + 1 + extra);
    endtask

    task automatic do_init();
        int first [N];
        logic bad [N];
        int done_cnt;
        reset_n = 1'b0;
        for (int i = 0; i < N; i++) req_valid[i] = 1'b0;
        repeat (3) @(negedge clk);
        for (int i = 0; i < N; i++) begin
            chk("rst_req_ready", 32'(req_ready[i]), 32'd0);
            chk("rst_rsp_valid", 32'(rsp_valid[i]), 32'd0);
            chk("rst_rdata",     rdata[i],          32'd0);
            chk("rst_rsp_err",   32'(rsp_err[i]),   32'd0);
            chk("rst_init_done", 32'(init_done[i]), 32'd0);
            for (int b = 0; b < 1024; b++) mdl[i][b] = 8'h00;
            first[i] = -1;
            bad[i]   = 1'b0;
        end
        done_cnt = 0;
        reset_n = 1'b1;
        for (int e = 1; e <= 2000 && done_cnt < N; e++) begin
            @(posedge clk);
            #1;
            for (int i = 0; i < N; i++) begin
                if (first[i] < 0) begin
                    if (init_done[i] === 1'b1) begin
                        first[i] = e;
                        done_cnt++;
                    end else if (req_ready[i] !== 1'b0) begin
                        bad[i] = 1'b1;
                    end
                end
            end
        end
        for (int i = 0; i < N; i++) begin
            chk("init_cycles",   first[i],    sz_of(i) / 4);
            chk("ready_in_init", 32'(bad[i]), 32'd0);
        end
    endtask

    // req_valid held high: second accept one cycle after the first response.
    task automatic back_to_back(input int i);
        int e1, gap;
        @(negedge clk);
        req_valid[i] = 1'b1; req_we[i] = 1'b0; addr[i] = 32'h0; fun3[i] = 3'b010; wdata[i] = 32'h0;
        e1 = -1; gap = -1;
        for (int e = 1; e <= 50; e++) begin
            @(posedge clk);
            #1;
            if (rsp_valid[i] === 1'b1) begin e1 = e; break; end
        end
        if (e1 > 0) begin
            chk("ready_in_rsp", 32'(req_ready[i]), 32'd0);
            for (int k = 1; k <= 50; k++) begin
                @(posedge clk);
                #1;
                if (rsp_valid[i] === 1'b1) begin gap = k; break; end
            end
        end
        @(negedge clk);
        req_valid[i] = 1'b0;
        chk("b2b_gap", gap, wait_of(i) + 3);
        repeat (3) @(negedge clk);
    endtask

    typedef struct {
        logic        we;
        logic [31:0] a;
        logic [2:0]  f3;
        logic [31:0] wd;
        logic [31:0] exp_rd;
        logic        exp_err;
    } vec_t;

    initial begin
        vec_t vecs [$];
        logic        seen;
        logic [31:0] ra;
        int          r, k;

        reset_n = 1'b0;
        for (int i = 0; i < N; i++) begin
            req_valid[i] = 1'b0; req_we[i] = 1'b0; addr[i] = 32'h0; fun3[i] = 3'b0; wdata[i] = 32'h0;
        end

        do_init();
        for (int i = 0; i < N; i++) run_op(i, 1'b0, 32'h0, 3'b010, 32'h0, 1'b1, 32'h0, 1'b0);

        vecs.push_back('{1'b1, 32'h0,   3'b010, 32'hAABBCCDD, 32'h0,        1'b0});
        vecs.push_back('{1'b1, 32'h4,   3'b010, 32'h11223344, 32'h0,        1'b0});
        vecs.push_back('{1'b1, 32'h2,   3'b001, 32'hFFFF5678, 32'h0,        1'b0});
        vecs.push_back('{1'b1, 32'h1,   3'b000, 32'h123456BB, 32'h0,        1'b0});
        vecs.push_back('{1'b0, 32'h0,   3'b010, 32'h0,        32'h5678BBDD, 1'b0});
        vecs.push_back('{1'b0, 32'h4,   3'b010, 32'h0,        32'h11223344, 1'b0});
        vecs.push_back('{1'b0, 32'h1,   3'b000, 32'h0,        32'hFFFFFFBB, 1'b0});
        vecs.push_back('{1'b0, 32'h1,   3'b100, 32'h0,        32'h000000BB, 1'b0});
        vecs.push_back('{1'b0, 32'h0,   3'b001, 32'h0,        32'hFFFFBBDD, 1'b0});
        vecs.push_back('{1'b0, 32'h2,   3'b101, 32'h0,        32'h00005678, 1'b0});
`ifdef MISALIGN_SPLIT_EN
        vecs.push_back('{1'b0, 32'h2,   3'b010, 32'h0,        32'h33445678, 1'b0});
`else
        vecs.push_back('{1'b0, 32'h2,   3'b010, 32'h0,        32'h0,        1'b1});
`endif
        vecs.push_back('{1'b1, 32'h400, 3'b010, 32'hDEADBEEF, 32'h0,        1'b1});
        vecs.push_back('{1'b0, 32'h0,   3'b011, 32'h0,        32'h0,        1'b1});
        vecs.push_back('{1'b1, 32'h0,   3'b100, 32'hFFFFFFFF, 32'h0,        1'b1});
        vecs.push_back('{1'b0, 32'h3FF, 3'b001, 32'h0,        32'h0,        1'b1});
        vecs.push_back('{1'b0, 32'h3FF, 3'b100, 32'h0,        32'h0,        1'b0});
        vecs.push_back('{1'b0, 32'h0,   3'b010, 32'h0,        32'h5678BBDD, 1'b0});
`ifdef MISALIGN_SPLIT_EN
        vecs.push_back('{1'b1, 32'h6,   3'b010, 32'hCAFEF00D, 32'h0,        1'b0});
        vecs.push_back('{1'b0, 32'h4,   3'b010, 32'h0,        32'hF00D3344, 1'b0});
        vecs.push_back('{1'b0, 32'h8,   3'b010, 32'h0,        32'h0000CAFE, 1'b0});
`else
        vecs.push_back('{1'b1, 32'h6,   3'b010, 32'hCAFEF00D, 32'h0,        1'b1});
        vecs.push_back('{1'b0, 32'h4,   3'b010, 32'h0,        32'h11223344, 1'b0});
        vecs.push_back('{1'b0, 32'h8,   3'b010, 32'h0,        32'h0,        1'b0});
`endif
        foreach (vecs[v]) begin
            run_op(0, vecs[v].we, vecs[v].a, vecs[v].f3, vecs[v].wd, 1'b1, vecs[v].exp_rd, vecs[v].exp_err);
        end

        back_to_back(1);
        back_to_back(2);

        for (int n = 0; n < 150; n++) begin
            r = int'($urandom_range(0, 9));
            if (r < 7)      ra = 32'($urandom_range(0, 47));
            else if (r < 9) ra = 32'(sz_of(0) - 6) + 32'($urandom_range(0, 8));
            else            ra = $urandom;
            run_op(0, 1'($urandom_range(0, 1)), ra, 3'($urandom_range(0, 7)), $urandom, 1'b0, 32'h0, 1'b0);
        end
        for (int i = 1; i < N; i++) begin
            for (int n = 0; n < 40; n++) begin
                ra = 32'($urandom_range(0, sz_of(i) + 3));
                run_op(i, 1'($urandom_range(0, 1)), ra, 3'($urandom_range(0, 7)), $urandom, 1'b0, 32'h0, 1'b0);
            end
        end

        // Reset while an SW is waiting in BUSY: no response may follow.
        @(negedge clk);
        req_valid[0] = 1'b1; req_we[0] = 1'b1; addr[0] = 32'h0; fun3[0] = 3'b010; wdata[0] = 32'h12345678;
        k = 0;
        while (req_ready[0] !== 1'b1 && k < 100) begin
            @(negedge clk);
            k++;
        end
        @(posedge clk);
        @(negedge clk);
        reset_n = 1'b0;
        req_valid[0] = 1'b0;
        seen = 1'b0;
        repeat (5) begin
            @(posedge clk);
            #1;
            if (rsp_valid[0] !== 1'b0) seen = 1'b1;
        end
        chk("rsp_after_reset", 32'(seen), 32'd0);
        do_init();
        run_op(0, 1'b0, 32'h0, 3'b010, 32'h0, 1'b1, 32'h0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/data_memory_hs.md
Name: data_memory_hs

Overview:
- RV32I data memory with a valid/ready request channel, a registered response channel and a configurable number of wait states.
- Sits between the LSU and the word-organised data array.
- Decodes fun3 for all byte, halfword and word loads and stores, and flags misaligned, out-of-range and illegal accesses.
- Clears the whole array after every reset, one word per cycle.

Parameters:
- SIZE, 1024: memory size in bytes; power of two, at least 8; array holds SIZE/4 words of 32 bits.
- WAIT_CYCLES, 1: extra wait cycles before the access is performed; legal range 0..7.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted on an edge where req_valid and req_ready are both 1.
- req_we  in  1  1 = store, 0 = load.
- addr  in  32  byte address.
- fun3  in  3  RISC-V funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- wdata  in  32  store data; low byte/half/word is used.
- rsp_valid  out  1  one-cycle response pulse.
- rdata  out  32  load result, sign- or zero-extended; 0 for stores and errors.
- rsp_err  out  1  qualified by rsp_valid.
- init_done  out  1  high once the post-reset clear has finished.

Behaviour:
- Reset (asynchronous):
  - state=INIT, clear index=0.
  - req_ready=0, rsp_valid=0, rdata=0, rsp_err=0, init_done=0.
  - Any in-flight request is dropped with no response.
- INIT:
  - Writes 0 to word[idx] each cycle; SIZE/4 cycles total.
  - After the last word: state=IDLE, init_done=1 (stays 1 until the next reset).
  - Requests are ignored; req_ready=0.
- IDLE:
  - req_ready=1.
  - On accept: latch req_we, addr, fun3, wdata; cnt=WAIT_CYCLES; state=BUSY; req_ready=0 from the next cycle.
- BUSY:
  - If cnt != 0: decrement cnt.
  - If cnt == 0: perform the access on this edge, register rdata and rsp_err, set rsp_valid=1, state=RESP.
- RESP:
  - rsp_valid high for exactly one cycle, then rsp_valid=0, state=IDLE.
  - rdata and rsp_err hold their values until the next response.
- Latency: rsp_valid is high in the cycle beginning WAIT_CYCLES+1 edges after the accept edge. req_ready returns one cycle after the response. No pipelining; one outstanding request.
- Store merge (read-modify-write of one word):
  - SB replaces byte lane addr[1:0].
  - SH replaces half lane addr[1].
  - SW replaces the whole word.
- Load extraction:
  - LB/LH sign-extend; LBU/LHU zero-extend; LW returns the whole word.
- Errors (rsp_err=1, array unchanged, rdata=0):
  - fun3 in {011, 110, 111}.
  - Store with fun3 100 or 101.
  - addr >= SIZE, checked on the access's last byte, i.e. addr + access size - 1 >= SIZE.
  - Misalignment: H with addr[0]=1, or W with addr[1:0] != 0. Whether this errors depends on MISALIGN_SPLIT_EN (see Optional Feature).
- Inputs are sampled only at the accept edge; changes during BUSY/RESP have no effect.
- Byte order: little-endian; byte 0 is bits 7:0 of word 0.

Optional Feature:
- Macro: MISALIGN_SPLIT_EN.
- Defined:
  - Misaligned H/W accesses that cross a word boundary are split over words A=addr>>2 and A+1.
  - BUSY spends one extra cycle, so latency is WAIT_CYCLES+2.
  - First edge reads or merges word A; second edge handles word A+1.
  - Stores merge bytes in little-endian order; loads assemble and extend as normal.
  - If A+1 is out of range: rsp_err=1 and neither word is modified.
  - Misaligned H accesses that do not cross a word boundary complete with normal latency.
- Undefined: misaligned accesses return rsp_err=1 with no array change and normal latency.

Test Plan:
- Reset then wait SIZE/4 cycles: init_done rises exactly after SIZE/4 cycles; req_ready=0 before that; LW 0x0 then returns 0x00000000.
- Store sequence:
  - SW 0x0=0xAABBCCDD, SW 0x4=0x11223344, SH 0x2=0x5678, SB 0x1=0xBB.
  - LW 0x0 -> 0x5678BBDD; LW 0x4 -> 0x11223344.
- Sign/zero extension on word 0x0 = 0x5678BBDD:
  - LB 0x1 -> 0xFFFFFFBB; LBU 0x1 -> 0x000000BB.
  - LH 0x0 -> 0xFFFFBBDD; LHU 0x2 -> 0x00005678.
- Latency with WAIT_CYCLES=0 and =3: rsp_valid exactly 1 and 4 edges after the accept edge, one cycle wide; req_valid held high is accepted again one cycle after the response.
- Errors:
  - LW 0x2, SW at SIZE, fun3=011, store with fun3=100 -> rsp_err=1, rdata=0, memory unchanged.
  - With MISALIGN_SPLIT_EN: SW 0x6=0xCAFEF00D then LW 0x4 -> 0xF00D3344 and LW 0x8 -> 0x0000CAFE, with latency WAIT_CYCLES+2.
- Reset mid-operation: assert reset_n=0 during BUSY of an SW 0x0=0x12345678 -> rsp_valid never rises; after re-init, LW 0x0 -> 0x00000000.
